count_sequencer: RTL and testbench

Controller that sequences a modulo-N up-counter datapath. It accepts a run command carrying a modulus and a lap count through a valid/ready handshake. It then steps the count output Q through 0..MOD-1 for the requested number of wrap-arounds and signals completion. The block supports pause (HOLD) and cancel (ABORT), and drives the same Q/CLK/RESET style interface the counter blocks use, so it can replace a free-running counter or supervise one.

---
 rtl/count_sequencer.sv | 148 ++++++++++++++
 tb/tb_count_sequencer.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/count_sequencer.sv
// Command-driven modulo-N counter sequencer: runs Q through 0..MOD-1 for a
// requested number of laps, with pause (HOLD) and cancel (ABORT) support.
module count_sequencer #(
  parameter int WIDTH = 3,
  parameter int LAP_W = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [WIDTH-1:0] CMD_MOD,
  input  logic [LAP_W-1:0] CMD_LAPS,
  input  logic             HOLD,
  input  logic             ABORT,
  output logic [WIDTH-1:0] Q,
  output logic             WRAP,
  output logic [LAP_W-1:0] LAP,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [LAP_W-1:0] lap_q, lap_d;
  logic [WIDTH-1:0] mod_q, mod_d;
  logic [LAP_W-1:0] laps_q, laps_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] mod_m1;
  logic [LAP_W-1:0] lap_inc;
  logic             cmd_bad;

  assign mod_m1  = mod_q - 1'b1;
  assign lap_inc = lap_q + 1'b1;
  assign cmd_bad = (CMD_MOD < WIDTH'(2)) || (CMD_LAPS == '0);

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    lap_d   = lap_q;
    mod_d   = mod_q;
    laps_d  = laps_q;
    wrap_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    busy_d  = busy_q;

    unique case (state_q)
      S_IDLE: begin
        if (CMD_VALID) begin
          if (cmd_bad) begin
            err_d = 1'b1;
          end else begin
            mod_d   = CMD_MOD;
            laps_d  = CMD_LAPS;
            q_d     = '0;
            lap_d   = '0;
            busy_d  = 1'b1;
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        if (ABORT) begin
          state_d = S_IDLE;
          q_d     = '0;
          busy_d  = 1'b0;
        end else if (HOLD) begin
          state_d = S_PAUSED;
        end else if (q_q == mod_m1) begin
          q_d    = '0;
          wrap_d = 1'b1;
          lap_d  = lap_inc;
          if (lap_inc == laps_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end else begin
          q_d = q_q + 1'b1;
        end
      end

      // Leaving PAUSED costs one extra stalled edge: no increment on resume.
      S_PAUSED: begin
        if (ABORT) begin
          state_d = S_IDLE;
          q_d     = '0;
          busy_d  = 1'b0;
        end else if (!HOLD) begin
          state_d = S_RUN;
        end
      end

      default: begin
        state_d = S_IDLE;
        q_d     = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      lap_q   <= '0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      lap_q   <= lap_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // Run parameters are only meaningful while busy, so they need no reset.
  always_ff @(posedge CLK) begin
    mod_q  <= mod_d;
    laps_q <= laps_d;
  end

  assign CMD_READY = (state_q == S_IDLE);
  assign Q         = q_q;
  assign LAP       = lap_q;
  assign WRAP      = wrap_q;
  assign DONE      = done_q;
  assign ERR       = err_q;
  assign BUSY      = busy_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer: directed scenarios then random traffic, all
// checked each cycle against a step-count arithmetic model.
module tb_count_sequencer;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       CMD_VALID = 1'b0;
  logic       CMD_READY;
  logic [2:0] CMD_MOD = '0;
  logic [3:0] CMD_LAPS = '0;
  logic       HOLD = 1'b0;
  logic       ABORT = 1'b0;
  logic [2:0] Q;
  logic       WRAP;
  logic [3:0] LAP;
  logic       BUSY;
  logic       DONE;
  logic       ERR;

  count_sequencer #(.WIDTH(3), .LAP_W(4)) dut (
    .CLK(CLK), .RESET(RESET), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_MOD(CMD_MOD), .CMD_LAPS(CMD_LAPS), .HOLD(HOLD), .ABORT(ABORT),
    .Q(Q), .WRAP(WRAP), .LAP(LAP), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_miss = 0;

  // Reference: a run is "n steps taken" of m*l total; Q and LAP follow from n.
  int act = 0, pz = 0, n = 0, m = 2, l = 1;
  int e_lap = 0, e_wrap = 0, e_done = 0, e_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model(input logic r, input logic v, input int mc, input int lc,
                       input logic h, input logic a);
    e_wrap = 0; e_done = 0; e_err = 0;
    if (!r) begin
      act = 0; pz = 0; n = 0; e_lap = 0;
    end else if (act == 0) begin
      if (v) begin
        if (mc < 2 || lc == 0) e_err = 1;
        else begin
          act = 1; pz = 0; n = 0; m = mc; l = lc; e_lap = 0;
        end
      end
    end else if (a) begin
      act = 0;
    end else if (pz != 0) begin
      if (!h) pz = 0;
    end else if (h) begin
      pz = 1;
    end else begin
      n++;
      e_lap = n / m;
      if (n % m == 0) e_wrap = 1;
      if (n == m * l) begin
        e_done = 1;
        act = 0;
      end
    end
  endtask

  task automatic step(input logic r, input logic v, input int mc, input int lc,
                      input logic h, input logic a);
    @(negedge CLK);
    RESET = r; CMD_VALID = v; CMD_MOD = 3'(mc); CMD_LAPS = 4'(lc);
    HOLD = h; ABORT = a;
    @(posedge CLK);
    model(r, v, mc, lc, h, a);
    #1;
    chk("Q", 32'(Q), 32'((act != 0) ? (n % m) : 0));
    chk("LAP", 32'(LAP), 32'(e_lap));
    chk("WRAP", 32'(WRAP), 32'(e_wrap));
    chk("DONE", 32'(DONE), 32'(e_done));
    chk("ERR", 32'(ERR), 32'(e_err));
    chk("BUSY", 32'(BUSY), 32'(act != 0));
    chk("CMD_READY", 32'(CMD_READY), 32'(act == 0));
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset state
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 5, 2, 1, 1);
    // Full run, modulus 5, two laps
    step(1, 1, 5, 2, 0, 0);
    idle(12);
    // Illegal commands
    step(1, 1, 1, 3, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 5, 0, 0, 0);
    step(1, 1, 0, 4, 0, 0);
    idle(2);
    // Hold for 3 edges at Q=2
    step(1, 1, 5, 1, 0, 0);
    idle(2);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1, 0);
    idle(8);
    // Abort at Q=3 in lap 2, and abort together with hold
    step(1, 1, 7, 3, 0, 0);
    idle(10);
    step(1, 0, 0, 0, 0, 1);
    idle(2);
    step(1, 1, 7, 3, 0, 0);
    idle(3);
    step(1, 0, 0, 0, 1, 1);
    step(1, 1, 6, 2, 1, 0);
    step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1, 1);
    idle(2);
    // Reset mid-run, then immediate accept
    step(1, 1, 6, 2, 0, 0);
    idle(4);
    step(0, 0, 0, 0, 0, 0);
    step(1, 1, 6, 1, 0, 0);
    idle(7);
    // Back-to-back with CMD_VALID held high
    for (int i = 0; i < 12; i++) step(1, 1, 3, 1, 0, 0);
    // Largest modulus and largest lap count
    step(1, 1, 7, 15, 0, 0);
    for (int i = 0; i < 110; i++) step(1, 0, 0, 0, 0, 0);
    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      logic r, v, h, a;
      int mc, lc;
      r  = ($urandom_range(0, 199) != 0);
      v  = ($urandom_range(0, 1) != 0);
      mc = $urandom_range(0, 7);
      lc = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
      h  = ($urandom_range(0, 7) == 0);
      a  = ($urandom_range(0, 39) == 0);
      step(r, v, mc, lc, h, a);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
